// File: rtl/comparador_digitos.sv
// -----------------------------------------------------------------------------
// comparador_digitos
//
// Digit-entry and comparison stage of the DigiLock datapath.
//
// The block collects four keypad digits into a buffer. Once the fourth digit
// arrives, one of two things happens:
//   - Compare mode: each buffered digit is compared against the stored password,
//     and the per-digit results go out on `comparacao` over four consecutive
//     clocks (digit 0 first).
//   - Programming mode: the buffered digits are written as the new password.
// The mode is taken from `programar` when the first digit of an entry arrives.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   tecla_valida  in   one-cycle strobe qualifying `tecla`
//   tecla   [3:0] in   0-9 digit, 4'hA clear, 4'hB-4'hF ignored
//   programar     in   mode select, sampled with the first digit of an entry
//   comparacao    out  per-digit match result while streaming, else 0
//   ocupado       out  high while streaming or writing (keys are dropped)
//   digitos_cnt   out  digits buffered in the current entry
//   senha_gravada out  one-cycle pulse when a new password is written
//   expirou       out  one-cycle pulse when a partial entry times out
//
// Parameters:
//   SENHA_PADRAO   password loaded at reset (digit 0 in [15:12])
//   TIMEOUT_CICLOS idle clocks allowed between digits (timeout build only)
//
// Build option:
//   COMPARADOR_TIMEOUT_EN  when defined, a partial entry that sees
//                          TIMEOUT_CICLOS idle clocks is discarded and
//                          `expirou` pulses. When undefined, `expirou`
//                          is always 0.
// -----------------------------------------------------------------------------
module comparador_digitos #(
  parameter logic [15:0] SENHA_PADRAO   = 16'h1234,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic       programar,
  output logic       comparacao,
  output logic       ocupado,
  output logic [2:0] digitos_cnt,
  output logic       senha_gravada,
  output logic       expirou
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    COMPARA = 2'd1,
    GRAVA   = 2'd2
  } estado_t;

  localparam logic [3:0] TECLA_LIMPA = 4'hA;
  localparam logic [3:0] DIGITO_MAX  = 4'd9;

  if (TIMEOUT_CICLOS < 1) begin : g_parametro_invalido
    $error("comparador_digitos: TIMEOUT_CICLOS must be at least 1");
  end

  // Return digit k of a packed four-digit word (digit 0 in the top nibble).
  function automatic logic [3:0] digito(input logic [15:0] v, input logic [1:0] k);
    logic [3:0] d;
    case (k)
      2'd0:    d = v[15:12];
      2'd1:    d = v[11:8];
      2'd2:    d = v[7:4];
      2'd3:    d = v[3:0];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  // Replace digit k of a packed four-digit word.
  function automatic logic [15:0] grava_digito(input logic [15:0] v,
                                               input logic [2:0]  k,
                                               input logic [3:0]  d);
    logic [15:0] r;
    r = v;
    case (k)
      3'd0:    r[15:12] = d;
      3'd1:    r[11:8]  = d;
      3'd2:    r[7:4]   = d;
      3'd3:    r[3:0]   = d;
      default: r        = v;
    endcase
    return r;
  endfunction

  estado_t     estado_r, estado_s;
  logic [1:0]  idx_r, idx_s;
  logic [15:0] buffer_r, buffer_s;
  logic [15:0] senha_r, senha_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        modo_r, modo_s;

  logic        comparacao_r, comparacao_s;
  logic        ocupado_r, ocupado_s;
  logic        senha_gravada_r, senha_gravada_s;
  logic        expirou_r, expirou_s;

  logic        aceita_s;
  logic        limpa_s;
  logic        expira_s;

  // Keys are only looked at while waiting; anything during a stream or write is dropped.
  assign aceita_s = (estado_r == ESPERA) && tecla_valida &&
                    (tecla <= DIGITO_MAX) && (cnt_r < 3'd4);
  assign limpa_s  = (estado_r == ESPERA) && tecla_valida && (tecla == TECLA_LIMPA);

`ifdef COMPARADOR_TIMEOUT_EN
  localparam logic [31:0] LIMITE_OCIOSO = 32'(TIMEOUT_CICLOS) - 32'd1;

  logic [31:0] ocioso_r;

  // An accepted digit or a clear in the expiry cycle takes priority over the timeout.
  assign expira_s = (estado_r == ESPERA) && (cnt_r != 3'd0) && !aceita_s && !limpa_s &&
                    (ocioso_r >= LIMITE_OCIOSO);

  // Idle counter: runs only while a partial entry waits for its next digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocioso_r <= 32'd0;
    end else if ((estado_r != ESPERA) || (cnt_r == 3'd0) || aceita_s || limpa_s || expira_s) begin
      ocioso_r <= 32'd0;
    end else begin
      ocioso_r <= ocioso_r + 32'd1;
    end
  end
`else
  assign expira_s = 1'b0;
`endif

  // State and datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= ESPERA;
      idx_r    <= 2'd0;
      buffer_r <= 16'h0000;
      senha_r  <= SENHA_PADRAO;
      cnt_r    <= 3'd0;
      modo_r   <= 1'b0;
    end else begin
      estado_r <= estado_s;
      idx_r    <= idx_s;
      buffer_r <= buffer_s;
      senha_r  <= senha_s;
      cnt_r    <= cnt_s;
      modo_r   <= modo_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_s = estado_r;
    idx_s    = idx_r;
    buffer_s = buffer_r;
    senha_s  = senha_r;
    cnt_s    = cnt_r;
    modo_s   = modo_r;
    case (estado_r)
      ESPERA: begin
        if (aceita_s) begin
          buffer_s = grava_digito(buffer_r, cnt_r, tecla);
          if (cnt_r == 3'd0) begin
            modo_s = programar;
          end else begin
            modo_s = modo_r;
          end
          // The count drops to 0 on the edge that takes the fourth digit.
          if (cnt_r == 3'd3) begin
            cnt_s    = 3'd0;
            idx_s    = 2'd0;
            estado_s = modo_s ? GRAVA : COMPARA;
          end else begin
            cnt_s = cnt_r + 3'd1;
          end
        end else if (limpa_s || expira_s) begin
          buffer_s = 16'h0000;
          cnt_s    = 3'd0;
          modo_s   = 1'b0;
        end else begin
          estado_s = ESPERA;
        end
      end
      COMPARA: begin
        if (idx_r == 2'd3) begin
          estado_s = ESPERA;
          idx_s    = 2'd0;
          buffer_s = 16'h0000;
        end else begin
          idx_s = idx_r + 2'd1;
        end
      end
      GRAVA: begin
        senha_s  = buffer_r;
        buffer_s = 16'h0000;
        modo_s   = 1'b0;
        estado_s = ESPERA;
      end
      default: begin
        estado_s = ESPERA;
        idx_s    = 2'd0;
        buffer_s = 16'h0000;
        cnt_s    = 3'd0;
        modo_s   = 1'b0;
      end
    endcase
  end

  // Output decode. This looks one cycle ahead so the outputs can be registered
  // and still line up with the state they describe.
  always_comb begin
    comparacao_s    = (estado_s == COMPARA) &&
                      (digito(buffer_s, idx_s) == digito(senha_s, idx_s));
    ocupado_s       = (estado_s != ESPERA);
    senha_gravada_s = (estado_s == GRAVA);
    expirou_s       = expira_s;
  end

  // Output register. Reset clears comparacao at once, even mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comparacao_r    <= 1'b0;
      ocupado_r       <= 1'b0;
      senha_gravada_r <= 1'b0;
      expirou_r       <= 1'b0;
    end else begin
      comparacao_r    <= comparacao_s;
      ocupado_r       <= ocupado_s;
      senha_gravada_r <= senha_gravada_s;
      expirou_r       <= expirou_s;
    end
  end

  assign comparacao    = comparacao_r;
  assign ocupado       = ocupado_r;
  assign digitos_cnt   = cnt_r;
  assign senha_gravada = senha_gravada_r;
  assign expirou       = expirou_r;

endmodule

// File: tb/tb_comparador_digitos.sv
// -----------------------------------------------------------------------------
// tb_comparador_digitos
//
// Self-checking bench for comparador_digitos.
//
// The reference model keeps the following:
//   - the password as an array of digits
//   - the current entry as a queue of digits
//   - a queue of expected per-cycle outputs that each completed entry schedules
//
// Inputs are driven on the falling edge. Outputs are sampled on the next
// falling edge, once the rising edge has been taken.
// -----------------------------------------------------------------------------
module tb_comparador_digitos;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tecla_valida;
  logic [3:0] tecla;
  logic       programar;
  logic       comparacao;
  logic       ocupado;
  logic [2:0] digitos_cnt;
  logic       senha_gravada;
  logic       expirou;

  always #5 clk = ~clk;

  comparador_digitos #(
    .SENHA_PADRAO  (16'h1234),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tecla_valida (tecla_valida),
    .tecla        (tecla),
    .programar    (programar),
    .comparacao   (comparacao),
    .ocupado      (ocupado),
    .digitos_cnt  (digitos_cnt),
    .senha_gravada(senha_gravada),
    .expirou      (expirou)
  );

  int checks = 0;
  int errors = 0;

  task automatic confere(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    checks++;
    if (obtido !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
    end
  endtask

  // Reference model.
  typedef struct packed {
    bit comp;
    bit ocup;
    bit grav;
  } saida_t;

  int     senha_m[4];
  int     entrada_m[$];
  bit     modo_m;
  saida_t fila_m[$];
  saida_t atual_m;
  bit     exp_m;
  int     ocioso_m;

  task automatic modelo_reset();
    senha_m = '{1, 2, 3, 4};
    entrada_m.delete();
    fila_m.delete();
    atual_m  = '0;
    modo_m   = 1'b0;
    exp_m    = 1'b0;
    ocioso_m = 0;
  endtask

  // One rising edge of the model. `atual_m` holds what the cycle that just
  // ended showed. After the call it holds the next cycle.
  task automatic modelo_borda(input bit v, input logic [3:0] t, input bit p);
    bit     aceito;
    bit     limpo;
    saida_t s;
    aceito = 1'b0;
    limpo  = 1'b0;
    exp_m  = 1'b0;
    if (!atual_m.ocup && v) begin
      if (t <= 4'd9) begin
        aceito = 1'b1;
        if (entrada_m.size() == 0) modo_m = p;
        entrada_m.push_back(int'(t));
        if (entrada_m.size() == 4) begin
          if (modo_m) begin
            s = '{comp: 1'b0, ocup: 1'b1, grav: 1'b1};
            fila_m.push_back(s);
            for (int k = 0; k < 4; k++) senha_m[k] = entrada_m[k];
          end else begin
            for (int k = 0; k < 4; k++) begin
              s.comp = (entrada_m[k] == senha_m[k]);
              s.ocup = 1'b1;
              s.grav = 1'b0;
              fila_m.push_back(s);
            end
          end
          entrada_m.delete();
          modo_m = 1'b0;
        end
      end else if (t == 4'hA) begin
        limpo = 1'b1;
        entrada_m.delete();
        modo_m = 1'b0;
      end
    end
`ifdef COMPARADOR_TIMEOUT_EN
    if (aceito || limpo || atual_m.ocup || entrada_m.size() == 0) begin
      ocioso_m = 0;
    end else begin
      ocioso_m++;
      if (ocioso_m == TMO) begin
        exp_m = 1'b1;
        entrada_m.delete();
        modo_m   = 1'b0;
        ocioso_m = 0;
      end
    end
`endif
    if (fila_m.size() > 0) atual_m = fila_m.pop_front();
    else atual_m = '0;
  endtask

  // Drive one cycle, advance the model, and check every output.
  task automatic passo(input bit v, input logic [3:0] t, input bit p);
    tecla_valida = v;
    tecla        = t;
    programar    = p;
    @(posedge clk);
    modelo_borda(v, t, p);
    @(negedge clk);
    confere("comparacao",    32'(comparacao),    32'(atual_m.comp));
    confere("ocupado",       32'(ocupado),       32'(atual_m.ocup));
    confere("senha_gravada", 32'(senha_gravada), 32'(atual_m.grav));
    confere("digitos_cnt",   32'(digitos_cnt),   32'(entrada_m.size()));
    confere("expirou",       32'(expirou),       32'(exp_m));
    tecla_valida = 1'b0;
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) passo(1'b0, 4'h0, 1'b0);
  endtask

  task automatic entra(input logic [15:0] cod, input bit p);
    logic [15:0] c;
    c = cod;
    for (int i = 0; i < 4; i++) begin
      passo(1'b1, c[15:12], p);
      c = c << 4;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    tecla_valida = 1'b0;
    tecla        = 4'h0;
    programar    = 1'b0;
    modelo_reset();
    repeat (3) @(negedge clk);
    confere("rst_comparacao",    32'(comparacao),    32'd0);
    confere("rst_ocupado",       32'(ocupado),       32'd0);
    confere("rst_digitos_cnt",   32'(digitos_cnt),   32'd0);
    confere("rst_senha_gravada", 32'(senha_gravada), 32'd0);
    confere("rst_expirou",       32'(expirou),       32'd0);
    rst_n = 1'b1;

    // Full match, then a mismatch on digit 2.
    entra(16'h1234, 1'b0);
    ocioso(6);
    entra(16'h1294, 1'b0);
    confere("cnt_zero_t1", 32'(digitos_cnt), 32'd0);
    ocioso(6);

    // Program 5678, then match against the new password.
    entra(16'h5678, 1'b1);
    ocioso(2);
    entra(16'h5678, 1'b0);
    ocioso(6);

    // Partial entry cleared, then a full entry with keys during the stream dropped.
    passo(1'b1, 4'd1, 1'b0);
    passo(1'b1, 4'd2, 1'b0);
    passo(1'b1, 4'hA, 1'b0);
    entra(16'h5678, 1'b0);
    passo(1'b1, 4'd7, 1'b0);
    passo(1'b1, 4'hA, 1'b0);
    passo(1'b1, 4'd3, 1'b1);
    passo(1'b1, 4'd9, 1'b0);
    confere("cnt_dropped", 32'(digitos_cnt), 32'd0);
    ocioso(2);

    // Asynchronous reset in the middle of a stream.
    entra(16'h5678, 1'b0);
    ocioso(1);
    #2 rst_n = 1'b0;
    #1;
    confere("async_rst_comparacao", 32'(comparacao), 32'd0);
    confere("async_rst_ocupado",    32'(ocupado),    32'd0);
    modelo_reset();
    @(negedge clk);
    rst_n = 1'b1;
    entra(16'h1234, 1'b0);
    ocioso(6);

`ifdef COMPARADOR_TIMEOUT_EN
    // A partial entry that stays idle long enough expires.
    passo(1'b1, 4'd1, 1'b0);
    ocioso(TMO);
    confere("timeout_expirou", 32'(expirou),     32'd1);
    confere("timeout_cnt",     32'(digitos_cnt), 32'd0);
    // A digit arriving in the expiry cycle is accepted instead.
    passo(1'b1, 4'd1, 1'b0);
    ocioso(TMO - 1);
    passo(1'b1, 4'd2, 1'b0);
    confere("timeout_race_cnt", 32'(digitos_cnt), 32'd2);
    passo(1'b1, 4'hA, 1'b0);
`else
    // Without the timeout a partial entry is held.
    passo(1'b1, 4'd1, 1'b0);
    ocioso(20);
    confere("hold_cnt", 32'(digitos_cnt), 32'd1);
    passo(1'b1, 4'hA, 1'b0);
`endif

    // Random traffic, biased toward correct digits so matches occur.
    for (int i = 0; i < 600; i++) begin
      bit         v;
      bit         p;
      logic [3:0] t;
      int         r;
      v = ($urandom_range(0, 1) == 1);
      p = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) t = 4'(senha_m[entrada_m.size() & 3]);
      else if (r < 9) t = 4'($urandom_range(0, 9));
      else t = 4'($urandom_range(10, 15));
      passo(v, t, p);
    end
    ocioso(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
